led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 159 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps through up to four 32-bit LED patterns and writes each one to a
//   single register through an AXI4-Lite master write channel.  Between
//   writes the sequencer idles for a programmable number of cycles.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   enable                 run the sequencer
//   period                 idle cycles between the end of one write and the next
//   num_steps              number of active steps minus one
//   pattern                four pattern words, step k at pattern[32k +: 32]
//   err_clr                clears the sticky error flag
//   M_AXI_AW*/W*/B*        AXI4-Lite write address, data and response channels
//   busy                   high whenever the FSM is not idle
//   step                   index of the most recently completed step
//   err                    sticky flag, set by a non-OKAY write response
//
// State table
//   state | meaning
//   IDLE  | stopped, waiting for enable
//   WAIT  | counting down the inter-write period
//   ADDR  | AW and W valids outstanding, each retires on its own handshake
//   RESP  | both accepted, BREADY high until BVALID

module led_pattern_sequencer #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 4,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_ADDR      = '0,
  parameter int                            C_PERIOD_WIDTH     = 24
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [C_PERIOD_WIDTH-1:0]     period,
  input  logic [1:0]                    num_steps,
  input  logic [127:0]                  pattern,
  input  logic                          err_clr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic                          busy,
  output logic [1:0]                    step,
  output logic                          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ADDR = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [C_PERIOD_WIDTH-1:0] CNT_ONE = {{(C_PERIOD_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  logic [C_PERIOD_WIDTH-1:0] cnt;
  logic [1:0]                ptr;
  logic                      aw_ok;
  logic                      w_ok;

  function automatic logic [C_M_AXI_DATA_WIDTH-1:0] word_at(input logic [127:0] pat,
                                                           input logic [1:0]   idx);
    return pat[{idx, 5'd0} +: C_M_AXI_DATA_WIDTH];
  endfunction

  // A channel is finished once its valid has dropped, or it handshakes this cycle.
  assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_ok  = !M_AXI_WVALID  || M_AXI_WREADY;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign busy         = (state != IDLE);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= 2'd0;
      step          <= 2'd0;
      err           <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      // Clear first so that a response error in the same cycle overrides it.
      if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            cnt           <= period;
            ptr           <= 2'd0;
            M_AXI_AWADDR  <= C_TARGET_ADDR;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WDATA   <= word_at(pattern, 2'd0);
            M_AXI_WVALID  <= 1'b1;
            state         <= ADDR;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            M_AXI_AWADDR  <= C_TARGET_ADDR;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WDATA   <= word_at(pattern, ptr);
            M_AXI_WVALID  <= 1'b1;
            state         <= ADDR;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ADDR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
          end
          if (aw_ok && w_ok) begin
            M_AXI_BREADY <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              err <= 1'b1;
            end
            step <= ptr;
            // >= rather than == so a shrunken num_steps never strands the pointer.
            ptr  <= (ptr >= num_steps) ? 2'd0 : ptr + 2'd1;
            cnt  <= period;
            state <= enable ? WAIT : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Drives led_pattern_sequencer against a configurable AXI4-Lite slave model.
//   Expected writes (data and step) are queued when a run is started and
//   compared whenever a write response handshake completes.

module tb_led_pattern_sequencer;

  localparam int PW = 24;

  logic           ACLK    = 1'b0;
  logic           ARESETN = 1'b1;
  logic           enable  = 1'b0;
  logic [PW-1:0]  period  = '0;
  logic [1:0]     num_steps = 2'd0;
  logic [127:0]   pattern = '0;
  logic           err_clr = 1'b0;

  logic [3:0]     M_AXI_AWADDR;
  logic [2:0]     M_AXI_AWPROT;
  logic           M_AXI_AWVALID;
  logic           M_AXI_AWREADY = 1'b0;
  logic [31:0]    M_AXI_WDATA;
  logic [3:0]     M_AXI_WSTRB;
  logic           M_AXI_WVALID;
  logic           M_AXI_WREADY = 1'b0;
  logic [1:0]     M_AXI_BRESP  = 2'b00;
  logic           M_AXI_BVALID = 1'b0;
  logic           M_AXI_BREADY;
  logic           busy;
  logic [1:0]     step;
  logic           err;

  led_pattern_sequencer dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .period        (period),
    .num_steps     (num_steps),
    .pattern       (pattern),
    .err_clr       (err_clr),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .busy          (busy),
    .step          (step),
    .err           (err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  step;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // slave model configuration
  int         aw_delay  = 0;
  int         w_delay   = 0;
  int         b_delay   = 0;
  logic [1:0] bresp_val = 2'b00;
  int         exp_gap   = 0;

  // handshakes seen at the last rising edge
  logic        aw_hs = 1'b0;
  logic        w_hs  = 1'b0;
  logic        b_hs  = 1'b0;
  logic [31:0] w_data_q  = '0;
  logic [3:0]  aw_addr_q = '0;

  int n_bhs = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.data = d;
    e.step = s;
    sb.push_back(e);
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
      @(negedge ACLK);
      #1;
    end
    check_val(tag, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(posedge ACLK) begin
    aw_hs <= M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs  <= M_AXI_WVALID && M_AXI_WREADY;
    b_hs  <= M_AXI_BVALID && M_AXI_BREADY;
    if (M_AXI_WVALID && M_AXI_WREADY)   w_data_q  <= M_AXI_WDATA;
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_addr_q <= M_AXI_AWADDR;
  end

  // Monitor, scoreboard and slave responder, all evaluated on the falling edge.
  initial begin
    automatic int   aw_wait = 0, w_wait = 0, b_wait = 0, gap_cnt = 0;
    automatic logic aw_seen = 0, w_seen = 0, outstanding = 0, gap_armed = 0, awv_prev = 0;
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_seen = 0; w_seen = 0; outstanding = 0; gap_armed = 0; awv_prev = 0;
        continue;
      end

      if (gap_armed) gap_cnt++;
      if (M_AXI_AWVALID && !awv_prev) begin
        check_val("aw_before_b", 64'(outstanding), 64'd0);
        if (gap_armed && exp_gap != 0) check_val("aw_gap", 64'(gap_cnt), 64'(exp_gap));
        gap_armed = 0;
      end
      awv_prev = M_AXI_AWVALID;
      if (aw_hs) outstanding = 1;

      if (b_hs) begin
        n_bhs++;
        outstanding = 0;
        gap_armed   = 1;
        gap_cnt     = 1;
        check_val("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("wr_data", 64'(w_data_q), 64'(e.data));
          check_val("wr_addr", 64'(aw_addr_q), 64'd0);
          check_val("wr_step", 64'(step), 64'(e.step));
        end
      end
      if (!busy) gap_armed = 0;

      if (aw_hs) begin
        M_AXI_AWREADY = 1'b0; aw_wait = 0; aw_seen = 1;
      end else if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
        if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
        else aw_wait++;
      end

      if (w_hs) begin
        M_AXI_WREADY = 1'b0; w_wait = 0; w_seen = 1;
      end else if (M_AXI_WVALID && !M_AXI_WREADY) begin
        if (w_wait >= w_delay) M_AXI_WREADY = 1'b1;
        else w_wait++;
      end

      if (b_hs) begin
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        aw_seen = 0; w_seen = 0; b_wait = 0;
      end else if (aw_seen && w_seen && !M_AXI_BVALID) begin
        if (b_wait >= b_delay) begin
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP  = bresp_val;
        end else begin
          b_wait++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_awvalid"}, 64'(M_AXI_AWVALID), 64'd0);
    check_val({pfx, "_wvalid"},  64'(M_AXI_WVALID),  64'd0);
    check_val({pfx, "_bready"},  64'(M_AXI_BREADY),  64'd0);
    check_val({pfx, "_busy"},    64'(busy),          64'd0);
    check_val({pfx, "_step"},    64'(step),          64'd0);
    check_val({pfx, "_err"},     64'(err),           64'd0);
    check_val({pfx, "_awaddr"},  64'(M_AXI_AWADDR),  64'd0);
    check_val({pfx, "_wdata"},   64'(M_AXI_WDATA),   64'd0);
    check_val({pfx, "_wstrb"},   64'(M_AXI_WSTRB),   64'hF);
    check_val({pfx, "_awprot"},  64'(M_AXI_AWPROT),  64'd0);
  endtask

  initial begin
    int n0;
    #2 ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    check_reset_outputs("rst");
    ARESETN = 1'b1;

    // back-to-back writes over four steps, period 0
    @(negedge ACLK); #1;
    pattern   = {32'd4, 32'd3, 32'd2, 32'd1};
    num_steps = 2'd3;
    period    = '0;
    exp_gap   = 2;
    push_exp(32'd1, 2'd0); push_exp(32'd2, 2'd1); push_exp(32'd3, 2'd2);
    push_exp(32'd4, 2'd3); push_exp(32'd1, 2'd0);
    enable = 1'b1;
    wait_sb_empty("t1_done");
    enable = 1'b0;
    check_val("t1_err", 64'(err), 64'd0);
    repeat (2) @(negedge ACLK); #1;
    check_val("t1_idle", 64'(busy), 64'd0);

    // period 5, single step
    pattern   = {96'd0, 32'hA5};
    num_steps = 2'd0;
    period    = 24'd5;
    exp_gap   = 7;
    repeat (3) push_exp(32'hA5, 2'd0);
    enable = 1'b1;
    wait_sb_empty("t2_done");
    enable = 1'b0;
    repeat (2) @(negedge ACLK); #1;

    // handshake skew, enable dropped while in ADDR
    aw_delay  = 3; w_delay = 0; b_delay = 2;
    pattern   = {96'd0, 32'h5A5A0001};
    period    = 24'd2;
    n0        = n_bhs;
    push_exp(32'h5A5A0001, 2'd0);
    enable = 1'b1;
    @(negedge ACLK); #1;
    enable = 1'b0;
    check_val("t3_busy_addr", 64'(busy), 64'd1);
    for (int i = 0; i < 50 && !w_hs; i++) begin @(negedge ACLK); #1; end
    check_val("t3_w_hs", 64'(w_hs), 64'd1);
    check_val("t3_wv_dropped", 64'(M_AXI_WVALID), 64'd0);
    check_val("t3_awv_held", 64'(M_AXI_AWVALID), 64'd1);
    for (int i = 0; i < 50 && !M_AXI_BREADY; i++) begin @(negedge ACLK); #1; end
    check_val("t3_bready", 64'(M_AXI_BREADY), 64'd1);
    check_val("t3_awv_dropped", 64'(M_AXI_AWVALID), 64'd0);
    wait_sb_empty("t3_done");
    check_val("t3_busy_end", 64'(busy), 64'd0);
    repeat (5) @(negedge ACLK); #1;
    check_val("t3_one_resp", 64'(n_bhs - n0), 64'd1);
    check_val("t3_still_idle", 64'(busy), 64'd0);
    aw_delay = 0; w_delay = 0; b_delay = 0;

    // error responses and err_clr priority
    bresp_val = 2'b10;
    pattern   = {64'd0, 32'h22, 32'h11};
    num_steps = 2'd1;
    period    = 24'd3;
    exp_gap   = 5;
    push_exp(32'h11, 2'd0); push_exp(32'h22, 2'd1); push_exp(32'h11, 2'd0);
    enable = 1'b1;
    for (int i = 0; i < 100 && sb.size() > 2; i++) begin @(negedge ACLK); #1; end
    check_val("t4_err_set", 64'(err), 64'd1);
    for (int i = 0; i < 100 && !(M_AXI_BVALID && M_AXI_BREADY); i++) begin @(negedge ACLK); #1; end
    check_val("t4_resp2", 64'(M_AXI_BVALID && M_AXI_BREADY), 64'd1);
    err_clr = 1'b1;
    @(negedge ACLK); #1;
    err_clr = 1'b0;
    check_val("t4_set_wins", 64'(err), 64'd1);
    wait_sb_empty("t4_done");
    enable    = 1'b0;
    bresp_val = 2'b00;
    repeat (3) @(negedge ACLK); #1;
    check_val("t4_err_sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge ACLK); #1;
    err_clr = 1'b0;
    check_val("t4_err_cleared", 64'(err), 64'd0);

    // num_steps shrunk below the pointer
    pattern   = {32'h44, 32'h33, 32'h22, 32'h11};
    num_steps = 2'd3;
    period    = 24'd4;
    exp_gap   = 6;
    push_exp(32'h11, 2'd0); push_exp(32'h22, 2'd1); push_exp(32'h33, 2'd2); push_exp(32'h11, 2'd0);
    enable = 1'b1;
    for (int i = 0; i < 200 && sb.size() > 2; i++) begin @(negedge ACLK); #1; end
    num_steps = 2'd1;
    wait_sb_empty("t5_done");
    enable = 1'b0;
    repeat (2) @(negedge ACLK); #1;

    // reset during RESP, then restart from step 0
    bresp_val = 2'b10;
    pattern   = {64'd0, 32'h66, 32'h55};
    num_steps = 2'd1;
    period    = '0;
    exp_gap   = 2;
    push_exp(32'h55, 2'd0); push_exp(32'h66, 2'd1);
    enable = 1'b1;
    wait_sb_empty("t6_first");
    check_val("t6_step_pre", 64'(step), 64'd1);
    check_val("t6_err_pre", 64'(err), 64'd1);
    for (int i = 0; i < 50 && !M_AXI_BREADY; i++) begin @(negedge ACLK); #1; end
    check_val("t6_in_resp", 64'(M_AXI_BREADY), 64'd1);
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    bresp_val = 2'b00;
    push_exp(32'h55, 2'd0); push_exp(32'h66, 2'd1);
    repeat (2) @(negedge ACLK);
    #1;
    ARESETN = 1'b1;
    wait_sb_empty("t6_restart");
    enable = 1'b0;
    check_val("t6_err_post", 64'(err), 64'd0);
    repeat (3) @(negedge ACLK); #1;
    check_val("t6_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
